// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 slave backed by a word-addressed SRAM array.
// Read and write channels run independent FSMs with configurable response latency.
module axi_sram_slave #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LAT_R      = 2,
  parameter int unsigned LAT_W      = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN   = 32'(64'(4) << DEPTH_LOG2);
  localparam int unsigned RCNT_W = (LAT_R > 1) ? $clog2(LAT_R) : 1;
  localparam int unsigned WCNT_W = (LAT_W > 1) ? $clog2(LAT_W) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  // Read channel state
  r_state_e          r_state_q, r_state_d;
  logic [RCNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [31:0]       ar_addr_q, ar_addr_d;
  logic [3:0]        ar_id_q, ar_id_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [3:0]        rid_q, rid_d;

  // Write channel state
  w_state_e          w_state_q, w_state_d;
  logic [WCNT_W-1:0] w_cnt_q, w_cnt_d;
  logic              aw_full_q, aw_full_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic [3:0]        aw_id_q, aw_id_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              w_last_q, w_last_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [3:0]        bid_q, bid_d;

  // Address decode for the captured read and write addresses
  logic [31:0]           r_off_c, w_off_c;
  logic                  r_hit_c, w_hit_c;
  logic [DEPTH_LOG2-1:0] r_idx_c, w_idx_c;
  logic                  mem_we_c;

  assign r_off_c = ar_addr_q - BASE;
  assign w_off_c = aw_addr_q - BASE;
  assign r_hit_c = r_off_c < SPAN;
  assign w_hit_c = w_off_c < SPAN;
  assign r_idx_c = r_off_c[DEPTH_LOG2+1:2];
  assign w_idx_c = w_off_c[DEPTH_LOG2+1:2];

  // Read FSM: accept AR, wait LAT_R cycles, sample array, hold response until rready
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    ar_len_d  = ar_len_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (io_slave_arvalid && arready_q) begin
          ar_addr_d = io_slave_araddr;
          ar_id_d   = io_slave_arid;
          ar_len_d  = io_slave_arlen;
          r_cnt_d   = RCNT_W'(LAT_R - 1);
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rvalid_d  = 1'b1;
          rid_d     = ar_id_q;
          r_state_d = R_RESP;
          if (!r_hit_c) begin
            rresp_d = RESP_DECERR;
            rdata_d = 32'h0;
          end else if (ar_len_q != 8'h0) begin
            rresp_d = RESP_SLVERR;
            rdata_d = 32'h0;
          end else begin
            rresp_d = RESP_OKAY;
            rdata_d = mem[r_idx_c];
          end
        end else begin
          r_cnt_d = RCNT_W'(r_cnt_q - 1'b1);
        end
      end
      R_RESP: begin
        if (io_slave_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      ar_addr_q <= 32'h0;
      ar_id_q   <= 4'h0;
      ar_len_q  <= 8'h0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= 4'h0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      ar_len_q  <= ar_len_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  // Write FSM: collect AW and W in any order, wait LAT_W cycles, commit and respond
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    aw_len_d  = aw_len_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_last_d  = w_last_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we_c  = 1'b0;
    unique case (w_state_q)
      W_COLLECT: begin
        if (io_slave_awvalid && awready_q) begin
          aw_addr_d = io_slave_awaddr;
          aw_id_d   = io_slave_awid;
          aw_len_d  = io_slave_awlen;
          aw_full_d = 1'b1;
        end
        if (io_slave_wvalid && wready_q) begin
          w_data_d = io_slave_wdata;
          w_strb_d = io_slave_wstrb;
          w_last_d = io_slave_wlast;
          w_full_d = 1'b1;
        end
        if (aw_full_d && w_full_d) begin
          w_cnt_d   = WCNT_W'(LAT_W - 1);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          bvalid_d  = 1'b1;
          bid_d     = aw_id_q;
          w_state_d = W_RESP;
          if (!w_hit_c) begin
            bresp_d = RESP_DECERR;
          end else if (aw_len_q != 8'h0 || !w_last_q) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d  = RESP_OKAY;
            mem_we_c = 1'b1;
          end
        end else begin
          w_cnt_d = WCNT_W'(w_cnt_q - 1'b1);
        end
      end
      W_RESP: begin
        if (io_slave_bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
    awready_d = (w_state_d == W_COLLECT) && !aw_full_d;
    wready_d  = (w_state_d == W_COLLECT) && !w_full_d;
  end

  // Write state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_COLLECT;
      w_cnt_q   <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= 32'h0;
      aw_id_q   <= 4'h0;
      aw_len_q  <= 8'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      w_last_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= 4'h0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      aw_len_q  <= aw_len_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_last_q  <= w_last_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  // Byte-masked array commit; a read sampling the same word this edge sees old data
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem[w_idx_c][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rid     = rid_q;
  assign io_slave_rlast   = rvalid_q;
  assign io_slave_awready = awready_q;
  assign io_slave_wready  = wready_q;
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;

  // Size/burst fields and high offset bits carry no meaning for this slave
  logic unused_c;
  assign unused_c = ^{io_slave_awsize, io_slave_awburst, io_slave_arsize,
                      io_slave_arburst, r_off_c, w_off_c};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave with hand-computed expectations.
module tb_axi_sram_slave;

  logic        clk;
  logic        rst_n;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arready, arvalid, rready, rvalid, rlast;

  int checks   = 0;
  int failures = 0;

  axi_sram_slave dut (
    .clock(clk), .reset(rst_n),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst), .io_slave_wready(wready), .io_slave_wvalid(wvalid),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid), .io_slave_arready(arready), .io_slave_arvalid(arvalid),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst), .io_slave_rready(rready),
    .io_slave_rvalid(rvalid), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together; B expected exactly one cycle after the handshake
  task automatic write_word(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                            input logic [3:0] s, input logic [7:0] len, input logic last,
                            input logic [1:0] exp_resp);
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len;
    wvalid  = 1'b1; wdata = d; wstrb = s; wlast = last;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("w_bvalid_early", 32'(bvalid), 32'd0);
    check("w_awready_busy", 32'(awready), 32'd0);
    step();
    check("w_bvalid", 32'(bvalid), 32'd1);
    check("w_bid", 32'(bid), 32'(id));
    check("w_bresp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("w_bvalid_clr", 32'(bvalid), 32'd0);
    check("w_awready_back", 32'(awready), 32'd1);
  endtask

  // AR then R two cycles later; hold cycles of rready=0 before accepting
  task automatic read_word(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int hold);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len;
    step();
    arvalid = 1'b0;
    check("r_arready_busy", 32'(arready), 32'd0);
    step();
    check("r_rvalid_early", 32'(rvalid), 32'd0);
    step();
    check("r_rvalid", 32'(rvalid), 32'd1);
    check("r_rdata", rdata, exp_data);
    check("r_rresp", 32'(rresp), 32'(exp_resp));
    check("r_rid", 32'(rid), 32'(id));
    check("r_rlast", 32'(rlast), 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, exp_data);
      check("bp_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("r_rvalid_clr", 32'(rvalid), 32'd0);
    check("r_arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b1; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    rready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rid_bid", {24'h0, rid, bid}, 32'h0);

    // Basic write then read
    write_word(32'h8000_0010, 4'd3, 32'hDEAD_BEEF, 4'hF, 8'd0, 1'b1, 2'b00);
    read_word(32'h8000_0010, 4'd5, 8'd0, 32'hDEAD_BEEF, 2'b00, 0);

    // W arrives one cycle before AW, partial strobe
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101; wlast = 1'b1;
    step();
    wvalid = 1'b0;
    check("ord_wready_full", 32'(wready), 32'd0);
    check("ord_awready_open", 32'(awready), 32'd1);
    check("ord_bvalid_none", 32'(bvalid), 32'd0);
    awvalid = 1'b1; awaddr = 32'h8000_0010; awid = 4'd7; awlen = 8'd0;
    step();
    awvalid = 1'b0;
    check("ord_bvalid_early", 32'(bvalid), 32'd0);
    step();
    check("ord_bvalid", 32'(bvalid), 32'd1);
    check("ord_bid", 32'(bid), 32'd7);
    check("ord_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    read_word(32'h8000_0012, 4'd1, 8'd0, 32'hDE22_BE44, 2'b00, 0);

    // Backpressure on R for five cycles
    read_word(32'h8000_0010, 4'd9, 8'd0, 32'hDE22_BE44, 2'b00, 5);

    // Error responses
    read_word(32'h0000_0100, 4'd2, 8'd0, 32'h0, 2'b11, 0);
    read_word(32'h8000_0010, 4'd2, 8'd1, 32'h0, 2'b10, 0);
    write_word(32'h8000_0010, 4'd4, 32'hCAFE_F00D, 4'hF, 8'd1, 1'b1, 2'b10);
    write_word(32'h8000_0010, 4'd4, 32'hCAFE_F00D, 4'hF, 8'd0, 1'b0, 2'b10);
    read_word(32'h8000_0010, 4'd6, 8'd0, 32'hDE22_BE44, 2'b00, 0);
    write_word(32'h9000_0000, 4'd8, 32'h1234_5678, 4'hF, 8'd0, 1'b1, 2'b11);

    // Top-of-array boundary
    write_word(32'h8000_3FFC, 4'd10, 32'hA5A5_5A5A, 4'hF, 8'd0, 1'b1, 2'b00);
    read_word(32'h8000_3FFC, 4'd11, 8'd0, 32'hA5A5_5A5A, 2'b00, 0);
    read_word(32'h8000_4000, 4'd12, 8'd0, 32'h0, 2'b11, 0);
    write_word(32'h7FFF_FFFC, 4'd13, 32'h0, 4'hF, 8'd0, 1'b1, 2'b11);

    // Read sample and write commit on the same edge to the same word
    write_word(32'h8000_0020, 4'd1, 32'hAAAA_AAAA, 4'hF, 8'd0, 1'b1, 2'b00);
    arvalid = 1'b1; araddr = 32'h8000_0020; arid = 4'd14; arlen = 8'd0;
    step();
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h8000_0020; awid = 4'd15; awlen = 8'd0;
    wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF; wlast = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("cc_rvalid_early", 32'(rvalid), 32'd0);
    step();
    check("cc_rvalid", 32'(rvalid), 32'd1);
    check("cc_bvalid", 32'(bvalid), 32'd1);
    check("cc_rdata_old", rdata, 32'hAAAA_AAAA);
    check("cc_rid", 32'(rid), 32'd14);
    check("cc_bid", 32'(bid), 32'd15);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    read_word(32'h8000_0020, 4'd3, 8'd0, 32'h5555_5555, 2'b00, 0);

    // Reset in the middle of a write: no response, no commit
    awvalid = 1'b1; awaddr = 32'h8000_0020; awid = 4'd2; awlen = 8'd0;
    wvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wlast = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_awready", 32'(awready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("mid_rst_bvalid_after", 32'(bvalid), 32'd0);
    read_word(32'h8000_0020, 4'd4, 8'd0, 32'h5555_5555, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
